op_encoder: RTL and testbench



---
 rtl/op_encoder.sv | 178 +++++++++++++++++
 tb/tb_op_encoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/op_encoder.sv
// Purpose: turns six raw push-buttons into debounced, prioritised, auto-repeating 5-bit operation strobes.
// Latency: DEBOUNCE_CYCLES+4 edges from the first sampling edge of a new level to the op_valid cycle.
// Backpressure: one-entry slot holds a command while busy=1; events arriving to a full, blocked slot pulse dropped.
module op_encoder #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] btn,
   input  logic       busy,
   output logic [4:0] operation,
   output logic       op_valid,
   output logic       dropped
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic [5:0]    sync1;
   logic [5:0]    sync2;
   logic [5:0]    stable;
   logic [5:0]    stable_d;
   logic [5:0]    press;
   logic [3:0]    dir_stable;
   logic [3:0]    dir_press;

   logic          rep_active;
   logic          rep_first;
   logic [1:0]    rep_btn;
   logic [RW-1:0] rep_cnt;
   logic          rep_held;
   logic          rep_fire;
   logic [1:0]    new_btn;
   logic [5:0]    rep_ev;

   logic [5:0]    ev;
   logic          ev_any;
   logic [2:0]    ev_code;
   logic          slot_full;
   logic [2:0]    slot_code;
   logic          emit;
   logic          accept;
   logic          drop;

   // Two-flop synchronizer for the asynchronous buttons.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Per-bit debounce: the stable state flips only after DEBOUNCE_CYCLES consecutive disagreeing edges.
   for (genvar i = 0; i < 6; i++) begin : g_db
      logic [DW-1:0] db_cnt;

      // Count consecutive disagreements; any agreement restarts the count.
      always_ff @(posedge clk) begin
         if (rst) begin
            db_cnt    <= '0;
            stable[i] <= 1'b0;
         end else if (sync2[i] != stable[i]) begin
            if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               db_cnt    <= '0;
               stable[i] <= ~stable[i];
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   // Delayed copy of the stable state, used to detect 0->1 press edges.
   always_ff @(posedge clk) begin
      if (rst) stable_d <= '0;
      else     stable_d <= stable;
   end

   assign press      = stable & ~stable_d;
   assign dir_stable = stable[5:2];
   assign dir_press  = press[5:2];
   assign rep_held   = dir_stable[rep_btn];
   assign rep_fire   = rep_active && rep_held &&
                       (rep_cnt == (rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));

   // Choose which direction the repeat timer follows when several are pressed together (left first).
   always_comb begin
      new_btn = 2'd0;
      if      (dir_press[0]) new_btn = 2'd0;
      else if (dir_press[1]) new_btn = 2'd1;
      else if (dir_press[2]) new_btn = 2'd2;
      else if (dir_press[3]) new_btn = 2'd3;
   end

   // Repeat timer: counts edges since the last press or repeat of the tracked direction.
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_active <= 1'b0;
         rep_first  <= 1'b0;
         rep_btn    <= 2'd0;
         rep_cnt    <= '0;
      end else if (|dir_press) begin
         rep_active <= 1'b1;
         rep_first  <= 1'b1;
         rep_btn    <= new_btn;
         rep_cnt    <= RW'(1);
      end else if (rep_active && !rep_held) begin
         rep_active <= 1'b0;
      end else if (rep_fire) begin
         rep_first <= 1'b0;
         rep_cnt   <= RW'(1);
      end else if (rep_active) begin
         rep_cnt <= rep_cnt + 1'b1;
      end
   end

   // Route a repeat back onto the bit of the button it belongs to, so it shares that button's priority.
   always_comb begin
      rep_ev = '0;
      if (rep_fire) begin
         case (rep_btn)
            2'd0:    rep_ev[2] = 1'b1;
            2'd1:    rep_ev[3] = 1'b1;
            2'd2:    rep_ev[4] = 1'b1;
            default: rep_ev[5] = 1'b1;
         endcase
      end
   end

   assign ev     = press | rep_ev;
   assign ev_any = |ev;

   // Fixed priority: cancel > select > left > right > up > down; losers vanish silently.
   always_comb begin
      ev_code = 3'd0;
      if      (ev[1]) ev_code = 3'd2;
      else if (ev[0]) ev_code = 3'd1;
      else if (ev[2]) ev_code = 3'd3;
      else if (ev[3]) ev_code = 3'd4;
      else if (ev[4]) ev_code = 3'd5;
      else if (ev[5]) ev_code = 3'd6;
   end

   // Emission skips the cycle right after a strobe so op_valid never stays high two cycles.
   assign emit   = slot_full && !busy && !op_valid;
   assign accept = ev_any && (!slot_full || emit);
   assign drop   = ev_any && !accept;

   // Slot and output registers: the slot drains and refills on the same edge, never overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_full <= 1'b0;
         slot_code <= 3'd0;
         op_valid  <= 1'b0;
         operation <= 5'd0;
         dropped   <= 1'b0;
      end else begin
         op_valid  <= emit;
         operation <= emit ? {2'b00, slot_code} : 5'd0;
         dropped   <= drop;
         if (accept) begin
            slot_full <= 1'b1;
            slot_code <= ev_code;
         end else if (emit) begin
            slot_full <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_op_encoder.sv
// Directed bench for op_encoder with short debounce/repeat constants.
// Edges are numbered by the bench; outputs are sampled 2 time units after each rising edge.
// Pulses and drops are logged with their edge number and compared against hand-derived schedules.
module tb_op_encoder;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic       clk;
   logic       rst;
   logic [5:0] btn;
   logic       busy;
   logic [4:0] operation;
   logic       op_valid;
   logic       dropped;

   int n_vec;
   int n_err;
   int ecnt;
   int base;
   int r;
   logic prev_vld;
   int pe[$];
   int po[$];
   int de[$];

   op_encoder #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn(btn),
      .busy(busy),
      .operation(operation),
      .op_valid(op_valid),
      .dropped(dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge, then sample and log outputs away from the edge.
   task automatic tick();
      @(posedge clk);
      ecnt++;
      #2;
      if (op_valid === 1'b1) begin
         pe.push_back(ecnt);
         po.push_back(32'(operation));
         chk("back_to_back_valid", 32'(prev_vld), 32'd0);
      end else begin
         chk("idle_operation", 32'(operation), 32'd0);
      end
      if (dropped === 1'b1) de.push_back(ecnt);
      prev_vld = op_valid;
   endtask

   task automatic wait_until(input int t);
      while (ecnt < t) tick();
   endtask

   task automatic clear_logs();
      pe.delete();
      po.delete();
      de.delete();
   endtask

   task automatic chk_pulse(input string tag, input int idx, input int exp_e, input int exp_op);
      int oe;
      int oo;
      oe = (idx < pe.size()) ? pe[idx] : -1;
      oo = (idx < po.size()) ? po[idx] : -1;
      chk({tag, "_edge"}, oe, exp_e);
      chk({tag, "_code"}, oo, exp_op);
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      ecnt     = 0;
      prev_vld = 1'b0;
      rst      = 1'b1;
      btn      = 6'b0;
      busy     = 1'b0;
      tick();
      tick();
      tick();
      chk("reset_op_valid", 32'(op_valid), 32'd0);
      chk("reset_operation", 32'(operation), 32'd0);
      chk("reset_dropped", 32'(dropped), 32'd0);

      // Left held from the first edge after reset: press pulse, then first repeat.
      clear_logs();
      rst  = 1'b0;
      btn  = 6'b000100;
      base = ecnt;
      wait_until(base + 24);
      btn = 6'b0;
      wait_until(base + 60);
      chk("left_count", pe.size(), 2);
      chk_pulse("left_press", 0, base + 8, 3);
      chk_pulse("left_repeat", 1, base + 28, 3);

      // Bouncing select: only the final settled level produces a pulse.
      clear_logs();
      base = ecnt;
      btn  = 6'b000001;
      wait_until(base + 2);
      btn = 6'b0;
      wait_until(base + 4);
      btn = 6'b000001;
      wait_until(base + 6);
      btn = 6'b0;
      wait_until(base + 8);
      btn  = 6'b000001;
      base = ecnt;
      wait_until(base + 30);
      chk("select_count", pe.size(), 1);
      chk_pulse("select", 0, base + 8, 1);
      btn = 6'b0;
      wait_until(base + 45);

      // Cancel and down on the same edge: cancel wins, down vanishes without a drop.
      clear_logs();
      base = ecnt;
      btn  = 6'b100010;
      wait_until(base + 6);
      btn = 6'b0;
      wait_until(base + 40);
      chk("same_edge_count", pe.size(), 1);
      chk_pulse("same_edge", 0, base + 8, 2);
      chk("same_edge_drops", de.size(), 0);

      // Up held long: press, delayed repeat, then periodic repeats until release.
      clear_logs();
      base = ecnt;
      btn  = 6'b010000;
      wait_until(base + 60);
      btn = 6'b0;
      wait_until(base + 100);
      chk("up_count", pe.size(), 6);
      chk_pulse("up_p0", 0, base + 8, 5);
      chk_pulse("up_p1", 1, base + 28, 5);
      chk_pulse("up_p2", 2, base + 36, 5);
      chk_pulse("up_p3", 3, base + 44, 5);
      chk_pulse("up_p4", 4, base + 52, 5);
      chk_pulse("up_p5", 5, base + 60, 5);

      // Busy downstream: right fills the slot, select is dropped, right drains after busy falls.
      clear_logs();
      busy = 1'b1;
      base = ecnt;
      btn  = 6'b001000;
      wait_until(base + 8);
      btn = 6'b0;
      wait_until(base + 10);
      btn = 6'b000001;
      wait_until(base + 18);
      btn = 6'b0;
      wait_until(base + 30);
      busy = 1'b0;
      wait_until(base + 50);
      chk("busy_drop_count", de.size(), 1);
      chk("busy_drop_edge", (de.size() > 0) ? de[0] : -1, base + 17);
      chk("busy_pulse_count", pe.size(), 1);
      chk_pulse("busy_right", 0, base + 31, 4);

      // Reset while left is repeating and still held: a fresh press follows reset release.
      clear_logs();
      base = ecnt;
      btn  = 6'b000100;
      wait_until(base + 38);
      chk("pre_reset_count", pe.size(), 3);
      clear_logs();
      rst = 1'b1;
      tick();
      chk("mid_reset_op_valid", 32'(op_valid), 32'd0);
      chk("mid_reset_operation", 32'(operation), 32'd0);
      rst = 1'b0;
      r   = ecnt;
      wait_until(r + 24);
      btn = 6'b0;
      wait_until(r + 60);
      chk("post_reset_count", pe.size(), 2);
      chk_pulse("post_reset_press", 0, r + 8, 3);
      chk_pulse("post_reset_repeat", 1, r + 28, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
